// File: rtl/cart_pkg.sv
// Shared definitions for the cartridge loader and the HPS upload path:
// FSM state encoding, parameter defaults and a saturating index helper.
package cart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2,
        PAD   = 2'd3
    } cart_state_e;

    localparam logic [7:0] PAD_BYTE_DEFAULT    = 8'hFF;
    localparam int         RAM_TIMEOUT_DEFAULT = 255;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cart_upload_if.sv
// Upload bus: the HPS ioctl byte handshake plus the cart RAM read port.
// The slave modport is the cart_upload side; master is the HPS/RAM environment.
interface cart_upload_if;

    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ram_rd;
    logic [14:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_valid;

    modport master (
        output ioctl_upload, ioctl_rd, ram_dout, ram_valid,
        input  ioctl_din, ioctl_wait, ram_rd, ram_addr
    );

    modport slave (
        input  ioctl_upload, ioctl_rd, ram_dout, ram_valid,
        output ioctl_din, ioctl_wait, ram_rd, ram_addr
    );

endinterface

// File: rtl/cart_timeout.sv
// Cycle counter bounding how long a cart RAM fetch may wait for ram_valid.
// It holds at LIMIT once reached so expired stays asserted until reloaded.
module cart_timeout
    import cart_pkg::*;
#(
    parameter int LIMIT = RAM_TIMEOUT_DEFAULT
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] count_q;

    assign expired = (count_q == W'(LIMIT));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/cart_upload.sv
// Streams the loaded cartridge image back to the HPS over ioctl, one RAM
// fetch per byte, padding with PAD_BYTE past the end of the image.
module cart_upload
    import cart_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE    = PAD_BYTE_DEFAULT,
    parameter int         RAM_TIMEOUT = RAM_TIMEOUT_DEFAULT
) (
    input  logic                clk_sys,
    input  logic                reset,
    cart_upload_if.slave        bus,
    input  logic [14:0]         cart_mask,
    output logic [15:0]         upload_len,
    output logic                busy,
    output logic                err
);

    cart_state_e state_q;
    logic        upload_q;
    logic [14:0] mask_q;
    logic [15:0] upload_len_q;
    logic [15:0] index_q;
    logic [7:0]  din_q;
    logic        wait_q;
    logic        ram_rd_q;
    logic [14:0] ram_addr_q;
    logic        busy_q;
    logic        err_q;

    logic [15:0] index_d;
    logic        upload_rise;
    logic        upload_fall;
    logic        goes_pad;
    logic        timer_load;
    logic        timer_en;
    logic        timer_expired;

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = wait_q;
    assign bus.ram_rd     = ram_rd_q;
    assign bus.ram_addr   = ram_addr_q;
    assign upload_len     = upload_len_q;
    assign busy           = busy_q;
    assign err            = err_q;

    always_comb begin
        upload_rise = bus.ioctl_upload & ~upload_q;
        upload_fall = ~bus.ioctl_upload & upload_q;
        index_d     = sat_inc16(index_q);
        goes_pad    = (index_d > {1'b0, mask_q});
        timer_load  = 1'b0;
        if (!upload_fall) begin
            if (state_q == IDLE && upload_rise) begin
                timer_load = 1'b1;
            end else if (state_q == READY && bus.ioctl_rd && !goes_pad) begin
                timer_load = 1'b1;
            end
        end
        timer_en = (state_q == FETCH);
    end

    cart_timeout #(
        .LIMIT (RAM_TIMEOUT)
    ) u_timeout (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (timer_load),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // upload_q resets high so a session still active across reset needs a
    // fresh low-then-high on ioctl_upload before it can restart.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            upload_q     <= 1'b1;
            mask_q       <= '0;
            upload_len_q <= '0;
            index_q      <= '0;
            din_q        <= '0;
            wait_q       <= 1'b0;
            ram_rd_q     <= 1'b0;
            ram_addr_q   <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            upload_q <= bus.ioctl_upload;
            ram_rd_q <= 1'b0;
            if (bus.ioctl_rd && wait_q && !upload_fall) begin
                err_q <= 1'b1;
            end
            if (upload_fall) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                wait_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (upload_rise) begin
                            mask_q       <= cart_mask;
                            upload_len_q <= {1'b0, cart_mask} + 16'd1;
                            index_q      <= '0;
                            busy_q       <= 1'b1;
                            wait_q       <= 1'b1;
                            ram_rd_q     <= 1'b1;
                            ram_addr_q   <= '0;
                            state_q      <= FETCH;
                        end
                    end
                    FETCH: begin
                        // ram_valid cannot legally coincide with our own strobe
                        if (bus.ram_valid && !ram_rd_q) begin
                            din_q   <= bus.ram_dout;
                            wait_q  <= 1'b0;
                            state_q <= READY;
                        end else if (timer_expired) begin
                            din_q   <= 8'h00;
                            err_q   <= 1'b1;
                            wait_q  <= 1'b0;
                            state_q <= READY;
                        end
                    end
                    READY: begin
                        if (bus.ioctl_rd) begin
                            index_q <= index_d;
                            wait_q  <= 1'b1;
                            if (goes_pad) begin
                                state_q <= PAD;
                            end else begin
                                ram_rd_q   <= 1'b1;
                                ram_addr_q <= index_d[14:0];
                                state_q    <= FETCH;
                            end
                        end
                    end
                    PAD: begin
                        if (wait_q) begin
                            din_q  <= PAD_BYTE;
                            wait_q <= 1'b0;
                        end else if (bus.ioctl_rd) begin
                            index_q <= index_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cart_upload.sv
// Directed bench for cart_upload: a 1-cycle-latency RAM model feeds a known
// image while the initial block plays the HPS side step by step.
module tb_cart_upload;
    import cart_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [14:0] cartMask = '0;
    logic [15:0] uploadLen;
    logic        busy;
    logic        err;

    logic        ramEnable  = 1'b1;
    logic        modelValid = 1'b0;
    logic [7:0]  modelData  = 8'h00;
    logic        forceValid = 1'b0;
    logic [7:0]  forceData  = 8'h00;
    int          ramRdCount = 0;

    int totalChecks = 0;
    int badChecks   = 0;

    cart_upload_if bus ();

    assign bus.ram_valid = modelValid | forceValid;
    assign bus.ram_dout  = forceValid ? forceData : modelData;

    cart_upload #(
        .PAD_BYTE    (8'hFF),
        .RAM_TIMEOUT (255)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bus        (bus),
        .cart_mask  (cartMask),
        .upload_len (uploadLen),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] imageByte(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA5;
    endfunction

    // Cart RAM model: answers each strobe one cycle later when enabled.
    always @(posedge clk_sys) begin
        modelValid <= ramEnable && bus.ram_rd;
        modelData  <= imageByte(bus.ram_addr);
        if (bus.ram_rd) ramRdCount <= ramRdCount + 1;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) else begin
            badChecks++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic upload, input logic rd);
        bus.ioctl_upload = upload;
        bus.ioctl_rd     = rd;
        @(negedge clk_sys);
        bus.ioctl_rd     = 1'b0;
    endtask

    task automatic waitWaitLow(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!bus.ioctl_wait) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic readByte(output logic [7:0] data, output bit ok);
        waitWaitLow(20, ok);
        data = bus.ioctl_din;
        applyStimulus(1'b1, 1'b1);
    endtask

    initial begin
        logic [7:0] data;
        bit         ok;
        int         lat;
        int         mism;
        int         tmo;
        int         rdBase;

        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd     = 1'b0;
        $display("[TB] starting cart_upload bench");

        repeat (3) @(negedge clk_sys);
        checkOutput("rst_din",  32'(bus.ioctl_din), 32'h00);
        checkOutput("rst_wait", 32'(bus.ioctl_wait), 32'h0);
        checkOutput("rst_rd",   32'(bus.ram_rd), 32'h0);
        checkOutput("rst_addr", 32'(bus.ram_addr), 32'h0);
        checkOutput("rst_len",  32'(uploadLen), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_err",  32'(err), 32'h0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Case 1: 4 KiB image, full readback
        cartMask = 15'h0FFF;
        rdBase   = ramRdCount;
        applyStimulus(1'b1, 1'b0);
        checkOutput("c1_start_rd",   32'(bus.ram_rd), 32'h1);
        checkOutput("c1_start_addr", 32'(bus.ram_addr), 32'h0);
        checkOutput("c1_start_wait", 32'(bus.ioctl_wait), 32'h1);
        checkOutput("c1_start_busy", 32'(busy), 32'h1);
        checkOutput("c1_len",        32'(uploadLen), 32'd4096);
        lat = 0;
        while (bus.ioctl_wait && lat < 50) begin
            @(negedge clk_sys);
            lat++;
        end
        checkOutput("c1_latency", 32'(lat), 32'd2);
        mism = 0;
        tmo  = 0;
        for (int i = 0; i < 4096; i++) begin
            readByte(data, ok);
            if (!ok) tmo++;
            if (data !== imageByte(15'(i))) mism++;
        end
        checkOutput("c1_timeouts",   32'(tmo), 32'd0);
        checkOutput("c1_mismatches", 32'(mism), 32'd0);
        waitWaitLow(20, ok);
        checkOutput("c1_pad_ok",  32'(ok), 32'h1);
        checkOutput("c1_pad",     32'(bus.ioctl_din), 32'hFF);
        checkOutput("c1_err",     32'(err), 32'h0);
        checkOutput("c1_rdcount", 32'(ramRdCount - rdBase), 32'd4096);
        applyStimulus(1'b0, 1'b0);
        checkOutput("c1_end_busy", 32'(busy), 32'h0);
        checkOutput("c1_end_wait", 32'(bus.ioctl_wait), 32'h0);

        // Case 2: 4-byte image, mask changed mid-session must not matter
        cartMask = 15'h0003;
        rdBase   = ramRdCount;
        applyStimulus(1'b1, 1'b0);
        cartMask = 15'h0FFF;
        checkOutput("c2_len", 32'(uploadLen), 32'd4);
        for (int i = 0; i < 6; i++) begin
            readByte(data, ok);
            checkOutput($sformatf("c2_ok%0d", i), 32'(ok), 32'h1);
            if (i < 4) checkOutput($sformatf("c2_byte%0d", i), 32'(data), 32'(imageByte(15'(i))));
            else       checkOutput($sformatf("c2_byte%0d", i), 32'(data), 32'hFF);
        end
        repeat (10) applyStimulus(1'b1, 1'b0);
        checkOutput("c2_rdcount", 32'(ramRdCount - rdBase), 32'd4);
        checkOutput("c2_err",     32'(err), 32'h0);
        applyStimulus(1'b0, 1'b0);

        // Case 3: RAM never answers
        ramEnable = 1'b0;
        applyStimulus(1'b1, 1'b0);
        lat = 0;
        while (bus.ioctl_wait && lat < 400) begin
            @(negedge clk_sys);
            lat++;
        end
        checkOutput("c3_latency", 32'(lat), 32'd256);
        checkOutput("c3_din",     32'(bus.ioctl_din), 32'h00);
        checkOutput("c3_err",     32'(err), 32'h1);
        checkOutput("c3_wait",    32'(bus.ioctl_wait), 32'h0);
        applyStimulus(1'b0, 1'b0);
        ramEnable = 1'b1;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("c3_err_cleared", 32'(err), 32'h0);
        applyStimulus(1'b0, 1'b0);

        // Case 4: ioctl_rd while ioctl_wait is high
        cartMask = 15'h000F;
        applyStimulus(1'b1, 1'b0);
        readByte(data, ok);
        checkOutput("c4_byte0", 32'(data), 32'(imageByte(15'd0)));
        checkOutput("c4_wait_hi", 32'(bus.ioctl_wait), 32'h1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("c4_err", 32'(err), 32'h1);
        for (int i = 1; i < 4; i++) begin
            readByte(data, ok);
            checkOutput($sformatf("c4_byte%0d", i), 32'(data), 32'(imageByte(15'(i))));
        end
        applyStimulus(1'b0, 1'b0);

        // Case 5: abort during FETCH, late ram_valid ignored
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) readByte(data, ok);
        ramEnable = 1'b0;
        checkOutput("c5_fetch_addr", 32'(bus.ram_addr), 32'd5);
        applyStimulus(1'b0, 1'b0);
        checkOutput("c5_busy", 32'(busy), 32'h0);
        checkOutput("c5_wait", 32'(bus.ioctl_wait), 32'h0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        forceData  = 8'h3C;
        forceValid = 1'b1;
        applyStimulus(1'b0, 1'b0);
        forceValid = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("c5_state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("c5_din",   32'(bus.ioctl_din), 32'(imageByte(15'd4)));
        checkOutput("c5_busy2", 32'(busy), 32'h0);
        ramEnable = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("c5_restart_rd",   32'(bus.ram_rd), 32'h1);
        checkOutput("c5_restart_addr", 32'(bus.ram_addr), 32'h0);
        readByte(data, ok);
        checkOutput("c5_restart_byte", 32'(data), 32'(imageByte(15'd0)));
        applyStimulus(1'b0, 1'b0);

        // Case 6: reset in READY at index 10
        cartMask = 15'h00FF;
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) readByte(data, ok);
        waitWaitLow(20, ok);
        checkOutput("c6_ready_ok",   32'(ok), 32'h1);
        checkOutput("c6_ready_byte", 32'(bus.ioctl_din), 32'(imageByte(15'd10)));
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("c6_din",  32'(bus.ioctl_din), 32'h00);
        checkOutput("c6_wait", 32'(bus.ioctl_wait), 32'h0);
        checkOutput("c6_rd",   32'(bus.ram_rd), 32'h0);
        checkOutput("c6_addr", 32'(bus.ram_addr), 32'h0);
        checkOutput("c6_len",  32'(uploadLen), 32'h0);
        checkOutput("c6_busy", 32'(busy), 32'h0);
        checkOutput("c6_err",  32'(err), 32'h0);
        reset  = 1'b0;
        rdBase = ramRdCount;
        repeat (5) applyStimulus(1'b1, 1'b0);
        checkOutput("c6_no_restart_busy", 32'(busy), 32'h0);
        checkOutput("c6_no_restart_rd",   32'(ramRdCount - rdBase), 32'd0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("c6_restart_busy", 32'(busy), 32'h1);
        checkOutput("c6_restart_rd",   32'(bus.ram_rd), 32'h1);
        checkOutput("c6_restart_addr", 32'(bus.ram_addr), 32'h0);
        readByte(data, ok);
        checkOutput("c6_restart_byte", 32'(data), 32'(imageByte(15'd0)));
        applyStimulus(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
